// File: rtl/adder_n_if.sv
// adder_n_if: operand/result bundle for the registered adder.
// Optional macro ADDER_OVF_EN adds the signed-overflow flag Ovf.
interface adder_n_if #(
  parameter int unsigned n = 32
);
  logic         In_valid;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         Cin;
  logic [n-1:0] Sum;
  logic         Cout;
  logic         Out_valid;
`ifdef ADDER_OVF_EN
  logic         Ovf;

  modport master (
    output In_valid, A, B, Cin,
    input  Sum, Cout, Out_valid, Ovf
  );

  modport slave (
    input  In_valid, A, B, Cin,
    output Sum, Cout, Out_valid, Ovf
  );
`else
  modport master (
    output In_valid, A, B, Cin,
    input  Sum, Cout, Out_valid
  );

  modport slave (
    input  In_valid, A, B, Cin,
    output Sum, Cout, Out_valid
  );
`endif
endinterface

// File: rtl/adder_n.sv
// adder_n: registered n-bit adder on a 4-bit-group carry-lookahead core.
// Result {Cout, Sum} = A + B + Cin, valid one clock after In_valid.
// Optional macro ADDER_OVF_EN registers the signed-overflow flag Ovf.
module adder_n #(
  parameter int unsigned n = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  adder_n_if.slave  bus
);

  localparam int unsigned NG = n / 4;

  logic [n-1:0]  g;
  logic [n-1:0]  p;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;
  logic [n-1:0]  bit_c;
  logic [n-1:0]  sum_d;
  logic          cout_d;

  logic [n-1:0]  sum_q;
  logic          cout_q;
  logic          valid_q;

  // Per-bit generate/propagate and per-group lookahead terms.
  always_comb begin
    g     = bus.A & bus.B;
    p     = bus.A ^ bus.B;
    grp_g = '0;
    grp_p = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Group carries from group G/P, then bit carries inside each group.
  always_comb begin
    grp_c    = '0;
    bit_c    = '0;
    grp_c[0] = bus.Cin;
    for (int unsigned k = 0; k < NG; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int unsigned k = 0; k < NG; k++) begin
      bit_c[4*k]   = grp_c[k];
      bit_c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      bit_c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                   | (p[4*k+1] & p[4*k] & grp_c[k]);
      bit_c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                   | (p[4*k+2] & p[4*k+1] & g[4*k])
                   | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
    sum_d  = p ^ bit_c;
    cout_d = grp_c[NG];
  end

  // Result registers load on In_valid and hold otherwise; valid follows In_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.In_valid;
      if (bus.In_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Out_valid = valid_q;

`ifdef ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: like-signed operands producing a differently signed sum.
  always_comb begin
    ovf_d = (bus.A[n-1] == bus.B[n-1]) && (sum_d[n-1] != bus.A[n-1]);
  end

  // Overflow flag register, loads and holds alongside Sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.In_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_n.sv
// tb_adder_n: randomized self-checking bench for adder_n (n = 32).
// Reference model uses plain wide arithmetic; Ovf checked when ADDER_OVF_EN is defined.
module tb_adder_n;

  logic clk;
  logic rst_n;

  adder_n_if #(.n(32)) bus ();

  adder_n #(.n(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [31:0] exp_sum;
  logic        exp_cout;
  logic        exp_valid;
  logic        exp_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_sum"},   64'(bus.Sum),       64'(exp_sum));
    check({tag, "_cout"},  64'(bus.Cout),      64'(exp_cout));
    check({tag, "_valid"}, 64'(bus.Out_valid), 64'(exp_valid));
`ifdef ADDER_OVF_EN
    check({tag, "_ovf"},   64'(bus.Ovf),       64'(exp_ovf));
`endif
  endtask

  task automatic model_reset();
    exp_sum   = '0;
    exp_cout  = 1'b0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance past the edge, update model, compare.
  task automatic step(input string tag, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic c);
    logic [32:0]        full;
    logic signed [33:0] ssum;
    bus.In_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = c;
    @(posedge clk);
    if (v) begin
      full     = {1'b0, a} + {1'b0, b} + 33'(c);
      exp_sum  = full[31:0];
      exp_cout = full[32];
      ssum     = 34'(signed'(a)) + 34'(signed'(b)) + 34'(c);
      exp_ovf  = (ssum > 34'sd2147483647) || (ssum < -34'sd2147483648);
    end
    exp_valid = v;
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rv, rc;

    rst_n        = 1'b0;
    bus.In_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.Cin      = 1'b0;
    model_reset();

    #3;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;

    step("idle_after_rst", 1'b0, 32'h1234_5678, 32'h9abc_def0, 1'b1);
    step("allones_plus0",  1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    step("cin_only",       1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
    step("b2b_1_3_cin",    1'b1, 32'h0000_0001, 32'h0000_0003, 1'b1);
    step("full_ripple",    1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    step("hold_ignore",    1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    step("pos_ovf",        1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step("neg_ovf",        1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step("no_ovf_mixed",   1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    step("hold_after",     1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'h0000_0000;
        1:       rb = ~ra;
        default: rb = $urandom;
      endcase
      step("rand", rv, ra, rb, rc);
    end

    // Load a nonzero result, then reset with a valid operand pending.
    step("pre_midrst", 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
    bus.In_valid = 1'b1;
    bus.A        = 32'd5;
    bus.B        = 32'd6;
    bus.Cin      = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst_async");
    @(posedge clk);
    #1;
    check_all("midrst_held");
    rst_n = 1'b1;
    step("post_rst_idle0", 1'b0, 32'd5, 32'd6, 1'b0);
    step("post_rst_idle1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step("post_rst_valid", 1'b1, 32'd5, 32'd6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
